// File: rtl/rf_queue_ctrl.sv
// rf_queue_ctrl: FIFO control over an external register file (registered read port)
// with a one-entry output stage fed directly by rf_rdata.
module rf_queue_ctrl #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_data,
  output logic                   push_rdy,
  output logic                   pop_vld,
  output logic [W-1:0]           pop_data,
  input  logic                   pop_rdy,
  input  logic                   flush,
  output logic [$clog2(N+2)-1:0] occupancy,
  output logic [$clog2(N)-1:0]   rf_wa,
  output logic                   rf_wen,
  output logic [W-1:0]           rf_wdata,
  output logic [$clog2(N)-1:0]   rf_ra,
  output logic                   rf_ren,
  input  logic [W-1:0]           rf_rdata
);
  localparam int AW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam int OW = $clog2(N + 2);
  if (N < 2 || (N & (N - 1)) != 0) begin : g_bad_n
    $error("rf_queue_ctrl: N must be a power of two and at least 2");
  end
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          push_fire, rd_issue;
  assign push_rdy  = (cnt != CW'(N)) & ~flush & rst;
  assign push_fire = push_vld & push_rdy;
  // a new read may only land when the output stage is empty or being drained
  assign rd_issue  = (cnt != '0) & (~pop_vld | pop_rdy) & ~flush & rst;
  assign rf_wen    = push_fire;
  assign rf_wa     = wr_ptr;
  assign rf_wdata  = push_data;
  assign rf_ren    = rd_issue;
  assign rf_ra     = rd_ptr;
  assign pop_data  = rf_rdata;
  assign occupancy = OW'(cnt) + OW'(pop_vld);
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      pop_vld <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push_fire);
      rd_ptr  <= rd_ptr + AW'(rd_issue);
      cnt     <= cnt + CW'(push_fire) - CW'(rd_issue);
      pop_vld <= rd_issue | (pop_vld & ~pop_rdy);
    end
  end
endmodule

// File: tb/tb_rf_queue_ctrl.sv
// tb_rf_queue_ctrl: directed bench for rf_queue_ctrl with a behavioural register file.
module tb_rf_queue_ctrl;
  localparam int W = 32;
  localparam int N = 8;
  logic          clk = 1'b0;
  logic          rst, push_vld, push_rdy, pop_vld, pop_rdy, flush, rf_wen, rf_ren;
  logic [W-1:0]  push_data, pop_data, rf_wdata, rf_rdata;
  logic [3:0]    occupancy;
  logic [2:0]    rf_wa, rf_ra;
  logic [W-1:0]  mem [N];
  int            errs = 0, checks = 0;
  rf_queue_ctrl #(.W(W), .N(N)) dut (
    .clk(clk), .rst(rst), .push_vld(push_vld), .push_data(push_data), .push_rdy(push_rdy),
    .pop_vld(pop_vld), .pop_data(pop_data), .pop_rdy(pop_rdy), .flush(flush),
    .occupancy(occupancy), .rf_wa(rf_wa), .rf_wen(rf_wen), .rf_wdata(rf_wdata),
    .rf_ra(rf_ra), .rf_ren(rf_ren), .rf_rdata(rf_rdata)
  );
  always #5 clk = ~clk;
  always_ff @(posedge clk) begin
    if (rf_wen) mem[rf_wa] <= rf_wdata;
    if (rf_ren) rf_rdata <= mem[rf_ra];
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [W-1:0] d);
    push_vld = 1'b1;
    push_data = d;
    step();
    push_vld = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] exp_v, held, maxo;
    logic        seen;
    rst = 1'b0; push_vld = 1'b1; push_data = '0; pop_rdy = 1'b0; flush = 1'b0;
    step();
    #1;
    chk("rst_push_rdy", push_rdy, 0);
    chk("rst_wen", rf_wen, 0);
    chk("rst_ren", rf_ren, 0);
    push_vld = 1'b0;
    step();
    // basic latency
    rst = 1'b1;
    push_vld = 1'b1; push_data = 32'hA5;
    #1;
    chk("post_rst_occ", occupancy, 0);
    chk("post_rst_pop_vld", pop_vld, 0);
    chk("post_rst_push_rdy", push_rdy, 1);
    chk("lat_wen", rf_wen, 1);
    step();
    push_vld = 1'b0;
    #1;
    chk("lat_ren_t1", rf_ren, 1);
    chk("lat_pop_vld_t1", pop_vld, 0);
    step();
    chk("lat_pop_vld_t2", pop_vld, 1);
    chk("lat_pop_data_t2", pop_data, 32'hA5);
    chk("lat_occ_t2", occupancy, 1);
    pop_rdy = 1'b1;
    step();
    pop_rdy = 1'b0;
    chk("lat_drained", occupancy, 0);
    // fill to capacity, crossing the pointer wrap
    for (int i = 1; i <= 9; i++) begin
      push_vld = 1'b1; push_data = i;
      #1;
      chk("fill_push_rdy", push_rdy, 1);
      step();
    end
    push_vld = 1'b0;
    #1;
    chk("full_push_rdy", push_rdy, 0);
    chk("full_occ", occupancy, 9);
    pop_rdy = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      #1;
      chk("fill_pop_vld", pop_vld, 1);
      chk("fill_pop_data", pop_data, i);
      step();
    end
    chk("fill_empty_vld", pop_vld, 0);
    chk("fill_empty_occ", occupancy, 0);
    // streaming
    exp_v = 100; seen = 1'b0; maxo = 0;
    push_vld = 1'b1;
    for (int i = 0; i < 46; i++) begin
      push_vld = (i < 40);
      push_data = 100 + i;
      #1;
      if (pop_vld) begin
        chk("stream_data", pop_data, exp_v);
        exp_v++;
      end else if (seen && exp_v != 140) chk("stream_gap", pop_vld, 1);
      seen |= pop_vld;
      if (occupancy > maxo) maxo = occupancy;
      step();
    end
    push_vld = 1'b0;
    chk("stream_count", exp_v, 140);
    chk("stream_maxocc", maxo, 2);
    // backpressure stability
    pop_rdy = 1'b0;
    push_word(32'h1111);
    push_word(32'h2222);
    chk("bp_vld", pop_vld, 1);
    held = pop_data;
    chk("bp_first", held, 32'h1111);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_stable", pop_data, held);
      chk("bp_no_ren", rf_ren, 0);
      step();
    end
    pop_rdy = 1'b1;
    step();
    chk("bp_second", pop_data, 32'h2222);
    step();
    pop_rdy = 1'b0;
    chk("bp_drained", occupancy, 0);
    // flush with a simultaneous push
    for (int i = 0; i < 5; i++) push_word(32'h50 + i);
    chk("fl_occ_before", occupancy, 5);
    flush = 1'b1; push_vld = 1'b1; push_data = 32'hEE;
    #1;
    chk("fl_push_rdy", push_rdy, 0);
    chk("fl_wen", rf_wen, 0);
    chk("fl_ren", rf_ren, 0);
    chk("fl_vld_same_cycle", pop_vld, 1);
    step();
    flush = 1'b0; push_vld = 1'b0;
    chk("fl_occ_after", occupancy, 0);
    chk("fl_vld_after", pop_vld, 0);
    push_word(32'h77);
    step();
    chk("fl_new_vld", pop_vld, 1);
    chk("fl_new_data", pop_data, 32'h77);
    pop_rdy = 1'b1;
    step();
    pop_rdy = 1'b0;
    chk("fl_no_ghost", pop_vld, 0);
    // reset mid-stream
    for (int i = 0; i < 4; i++) push_word(32'h60 + i);
    chk("mr_occ_before", occupancy, 4);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mr_occ_after", occupancy, 0);
    chk("mr_vld_after", pop_vld, 0);
    push_word(32'h33);
    chk("mr_vld_t1", pop_vld, 0);
    step();
    chk("mr_vld_t2", pop_vld, 1);
    chk("mr_data_t2", pop_data, 32'h33);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rf_queue_ctrl.md
RF_QUEUE_CTRL -- requirements
Module: rf_queue_ctrl

Interface
- REQ-001: Parameter W, default 32: entry width in bits.
- REQ-002: Parameter N, default 8: register-file depth; SHALL be a power of two and at least 2, with elaboration error otherwise.
- REQ-003: Port clk, input, 1: sole clock; all state is updated on its rising edge.
- REQ-004: Port rst, input, 1: reset, synchronous and active-low; state is cleared on a clk rising edge while rst=0.
- REQ-005: Port push_vld, input, 1: producer offers push_data this cycle.
- REQ-006: Port push_data, input, W: entry to enqueue.
- REQ-007: Port push_rdy, output, 1: the queue can accept an entry this cycle.
- REQ-008: Port pop_vld, output, 1: pop_data holds the head entry.
- REQ-009: Port pop_data, output, W: head entry, driven directly from rf_rdata.
- REQ-010: Port pop_rdy, input, 1: consumer accepts the head entry this cycle.
- REQ-011: Port flush, input, 1: discards all entries.
- REQ-012: Port occupancy, output, $clog2(N+2): total held entries (register file plus output stage).
- REQ-013: Ports rf_wa ($clog2(N)), rf_wen (1) and rf_wdata (W), outputs: single write port to an external register file with registered read output.
- REQ-014: Ports rf_ra ($clog2(N)) and rf_ren (1), outputs, plus rf_rdata (W), input: single read port; rf_rdata is valid in the cycle after rf_ren=1 and is held while rf_ren=0.

Function
- REQ-015: A push fire is push_vld & push_rdy; a pop fire is pop_vld & pop_rdy.
- REQ-016: The block SHALL keep wr_ptr, rd_ptr (each $clog2(N) bits, wrapping N-1 -> 0) and cnt (0..N), where cnt is the number of written, not-yet-read register-file entries.
- REQ-017: push_rdy SHALL be (cnt != N) & ~flush & rst; it does not depend on a same-cycle pop.
- REQ-018: On a push fire: rf_wen=1, rf_wa=wr_ptr, rf_wdata=push_data; wr_ptr increments.
- REQ-019: A read issue SHALL occur when cnt != 0 and (~pop_vld or pop fire) and ~flush.
- REQ-020: On a read issue: rf_ren=1, rf_ra=rd_ptr; rd_ptr increments.
- REQ-021: The next value of cnt SHALL be cnt + push fire - read issue; a same-cycle push and read issue leaves cnt unchanged.
- REQ-022: The next value of pop_vld SHALL be read issue | (pop_vld & ~pop_rdy).
- REQ-023: pop_data SHALL equal rf_rdata; while pop_vld=1 and pop_rdy=0, pop_data is stable because rf_ren=0.
- REQ-024: occupancy SHALL equal cnt + pop_vld; the maximum is N+1.
- REQ-025: Latency from a push fire on an empty queue in cycle t to pop_vld=1 with that data SHALL be 2 cycles (t+2).
- REQ-026: With pop_rdy held at 1 and cnt>0, the block SHALL sustain one pop per cycle.
- REQ-027: Entries SHALL pop in exact push order across pointer wrap-around.
- REQ-028: When cnt=N, rd_ptr equals wr_ptr; a read issue in that cycle reads the old entry, and no push occurs that cycle because push_rdy=0.
- REQ-029: When flush=1, the next state SHALL be wr_ptr=rd_ptr=0, cnt=0 and pop_vld=0.
- REQ-030: When flush=1, rf_wen=0 and rf_ren=0 in the same cycle; a push_vld in that cycle is dropped, and pop_vld is unaffected until the next edge.
- REQ-031: A pop fire and flush in the same cycle is legal; the popped entry is consumed.

Reset
- REQ-032: While rst=0, push_rdy=0, rf_wen=0 and rf_ren=0 combinationally.
- REQ-033: On a clock edge with rst=0, the block SHALL set wr_ptr=0, rd_ptr=0, cnt=0 and pop_vld=0.
- REQ-034: In the first cycle with rst=1, occupancy=0, pop_vld=0 and push_rdy=1.
- REQ-035: Reset asserted mid-operation SHALL discard all entries exactly as a flush does; register-file contents need no reset.

Verification
- REQ-036: Scenario, basic latency: after reset, push 0xA5 in cycle 0 -> rf_ren=1 in cycle 1, pop_vld=1 with pop_data=0xA5 in cycle 2, occupancy=1.
- REQ-037: Scenario, fill to capacity: N=8, push 9 entries (1..9) with pop_rdy=0 -> push_rdy=0 after the 9th accept, occupancy=9; then pop_rdy=1 -> pops 1..9 on consecutive cycles, then pop_vld=0 and occupancy=0.
- REQ-038: Scenario, streaming wrap: push_vld=pop_rdy=1 for 40 cycles with incrementing data -> in-order output, no gaps after the first pop, and occupancy never exceeds 2.
- REQ-039: Scenario, backpressure stability: pop_vld=1 with pop_rdy=0 for 5 cycles -> pop_data is constant and rf_ren=0 throughout.
- REQ-040: Scenario, flush: flush=1 with occupancy=5 and push_vld=1 in the same cycle -> next cycle occupancy=0, pop_vld=0, and the dropped push never appears.
- REQ-041: Scenario, reset mid-stream: rst=0 for 1 cycle with occupancy=4 -> next cycle occupancy=0 and pop_vld=0; a subsequent push appears at t+2.
